// File: rtl/cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter
//
// Purpose:
//   Shares the single main-memory port between the I-cache refill engine and
//   the D-cache refill/writeback engine. One requester owns the port at a time
//   and the arbiter sequences a BLOCK_WORDS-beat burst, advancing one beat per
//   MemAck. Read beats are steered to the granted cache with zero latency, and
//   write-data pops (DWReady) are returned to the D-cache. A one-cycle IDLE gap
//   always separates consecutive bursts.
//
// Configuration macro:
//   ARB_RR_EN  defined   -> round-robin tie-break. A last-granted flag resets
//                           to D, so the first tie after reset goes to I.
//              undefined -> fixed priority. The D-cache always wins a tie.
//
// Parameters:
//   ADDR_W       address width
//   DATA_W       data width
//   BLOCK_WORDS  beats per burst (power of two, >= 2)
//
// Ports:
//   CLK, ResetN            clock (rising edge), asynchronous active-low reset
//   IReq, IAddr            I-cache burst request and block address
//   IRData, IRValid, IDone I-cache read beat, beat valid, last beat done
//   DReq, DWe, DAddr       D-cache burst request, writeback flag, block address
//   DWData, DWReady        D-cache write beat and its accept pulse
//   DRData, DRValid, DDone D-cache read beat, beat valid, last beat done
//   MemReq, MemWe          memory beat request and write flag
//   MemAddr, MemWData      memory beat word address and write data
//   MemRData, MemAck       memory read data and beat acknowledge
//   Grant                  {D,I} one-hot owner, 00 when idle
//   Busy                   a burst is in progress
// ---------------------------------------------------------------------------
module cache_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 4
) (
  input  logic              CLK,
  input  logic              ResetN,
  input  logic              IReq,
  input  logic [ADDR_W-1:0] IAddr,
  output logic [DATA_W-1:0] IRData,
  output logic              IRValid,
  output logic              IDone,
  input  logic              DReq,
  input  logic              DWe,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [DATA_W-1:0] DWData,
  output logic              DWReady,
  output logic [DATA_W-1:0] DRData,
  output logic              DRValid,
  output logic              DDone,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData,
  input  logic              MemAck,
  output logic [1:0]        Grant,
  output logic              Busy
);

  localparam int BEAT_W = $clog2(BLOCK_WORDS);
  // Block offset in bytes: beat index plus the 2-bit byte-in-word field.
  localparam int OFF_W  = BEAT_W + 2;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2
  } state_e;

  state_e            state_q;
  logic [BEAT_W-1:0] beat_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [1:0]        grant_q;
  logic              busy_q;

  logic              pick_i_s;
  logic              pick_d_s;
  logic              granted_i_s;
  logic              granted_d_s;
  logic              last_beat_s;
  logic [BEAT_W-1:0] beat_n_s;

  // Block-offset address bits carry no information for a block-aligned burst.
  logic              unused_addr_bits_s;
  assign unused_addr_bits_s = ^{IAddr[OFF_W-1:0], DAddr[OFF_W-1:0]};

`ifdef ARB_RR_EN
  logic              last_d_q;

  // Last-granted side for the round-robin tie-break; resets to D so I wins the first tie.
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      last_d_q <= 1'b1;
    end else if ((state_q == ST_IDLE) && pick_i_s) begin
      last_d_q <= 1'b0;
    end else if ((state_q == ST_IDLE) && pick_d_s) begin
      last_d_q <= 1'b1;
    end else begin
      last_d_q <= last_d_q;
    end
  end
`endif

  // Request selection, only acted upon while the arbiter is IDLE.
  always_comb begin
    pick_i_s = 1'b0;
    pick_d_s = 1'b0;
    if (IReq && DReq) begin
`ifdef ARB_RR_EN
      if (last_d_q) begin
        pick_i_s = 1'b1;
      end else begin
        pick_d_s = 1'b1;
      end
`else
      pick_d_s = 1'b1;
`endif
    end else if (IReq) begin
      pick_i_s = 1'b1;
    end else if (DReq) begin
      pick_d_s = 1'b1;
    end else begin
      pick_i_s = 1'b0;
      pick_d_s = 1'b0;
    end
  end

  assign last_beat_s = (beat_q == LAST_BEAT);
  assign beat_n_s    = beat_q + BEAT_W'(1'b1);

  // Arbitration FSM with registered port-side outputs (MemReq/MemWe/MemAddr/Grant/Busy).
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      state_q    <= ST_IDLE;
      beat_q     <= {BEAT_W{1'b0}};
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= {ADDR_W{1'b0}};
      grant_q    <= 2'b00;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          beat_q <= {BEAT_W{1'b0}};
          if (pick_d_s) begin
            state_q    <= ST_GRANT_D;
            mem_req_q  <= 1'b1;
            mem_we_q   <= DWe;
            mem_addr_q <= {DAddr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            grant_q    <= 2'b10;
            busy_q     <= 1'b1;
          end else if (pick_i_s) begin
            state_q    <= ST_GRANT_I;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {IAddr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            grant_q    <= 2'b01;
            busy_q     <= 1'b1;
          end else begin
            state_q    <= ST_IDLE;
          end
        end
        ST_GRANT_I, ST_GRANT_D: begin
          // Without MemAck everything holds; the beat is simply re-presented.
          if (MemAck) begin
            beat_q <= beat_n_s;  // wraps to 0 after the last beat
            if (last_beat_s) begin
              state_q    <= ST_IDLE;
              mem_req_q  <= 1'b0;
              mem_we_q   <= 1'b0;
              mem_addr_q <= {ADDR_W{1'b0}};
              grant_q    <= 2'b00;
              busy_q     <= 1'b0;
            end else begin
              mem_addr_q <= {mem_addr_q[ADDR_W-1:OFF_W], beat_n_s, 2'b00};
            end
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          beat_q     <= {BEAT_W{1'b0}};
          mem_req_q  <= 1'b0;
          mem_we_q   <= 1'b0;
          mem_addr_q <= {ADDR_W{1'b0}};
          grant_q    <= 2'b00;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign granted_i_s = (state_q == ST_GRANT_I);
  assign granted_d_s = (state_q == ST_GRANT_D);

  assign MemReq   = mem_req_q;
  assign MemWe    = mem_we_q;
  assign MemAddr  = mem_addr_q;
  assign Grant    = grant_q;
  assign Busy     = busy_q;

  // Write data is a straight pass-through while a burst owns the port.
  assign MemWData = (state_q != ST_IDLE) ? DWData : {DATA_W{1'b0}};

  // Beat responses are combinational from MemAck so read data has zero latency.
  assign IRValid  = granted_i_s & MemAck;
  assign IRData   = IRValid ? MemRData : {DATA_W{1'b0}};
  assign IDone    = granted_i_s & MemAck & last_beat_s;

  assign DRValid  = granted_d_s & ~mem_we_q & MemAck;
  assign DRData   = DRValid ? MemRData : {DATA_W{1'b0}};
  assign DWReady  = granted_d_s & mem_we_q & MemAck;
  assign DDone    = granted_d_s & MemAck & last_beat_s;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

  localparam int BW = 4;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        CLK, ResetN;
  logic        IReq, DReq, DWe, MemAck;
  logic [31:0] IAddr, DAddr, DWData, MemRData;
  logic [31:0] IRData, DRData, MemAddr, MemWData;
  logic        IRValid, IDone, DWReady, DRValid, DDone, MemReq, MemWe, Busy;
  logic [1:0]  Grant;

  cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .BLOCK_WORDS(BW)) dut (
    .CLK(CLK), .ResetN(ResetN),
    .IReq(IReq), .IAddr(IAddr), .IRData(IRData), .IRValid(IRValid), .IDone(IDone),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData), .DWReady(DWReady),
    .DRData(DRData), .DRValid(DRValid), .DDone(DDone),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .MemAck(MemAck), .Grant(Grant), .Busy(Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int irv_pulses = 0;
  int idone_pulses = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  int          m_owner;   // 0 none, 1 I, 2 D
  int          m_beats;   // beats completed in current burst
  logic [31:0] m_base;
  bit          m_we;
  bit          m_last_d;

  logic        e_req, e_we, e_irv, e_idone, e_drv, e_ddone, e_dwr, e_busy;
  logic [31:0] e_addr, e_wd, e_ird, e_drd;
  logic [1:0]  e_grant;

  task automatic model_reset();
    m_owner = 0; m_beats = 0; m_base = 32'h0; m_we = 1'b0; m_last_d = 1'b1;
  endtask

  task automatic model_eval();
    bit ack;
    bit last;
    ack  = MemAck && (m_owner != 0);
    last = (m_beats == BW - 1);
    e_req   = (m_owner != 0);
    e_busy  = e_req;
    e_grant = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
    e_we    = (m_owner == 2) && m_we;
    e_addr  = e_req ? m_base + 32'(m_beats * 4) : 32'h0;
    e_wd    = e_req ? DWData : 32'h0;
    e_irv   = (m_owner == 1) && ack;
    e_ird   = e_irv ? MemRData : 32'h0;
    e_idone = e_irv && last;
    e_drv   = (m_owner == 2) && !m_we && ack;
    e_drd   = e_drv ? MemRData : 32'h0;
    e_dwr   = (m_owner == 2) && m_we && ack;
    e_ddone = (m_owner == 2) && ack && last;
  endtask

  task automatic model_step();
    int win;
    win = 0;
    if (m_owner == 0) begin
      if (IReq && DReq) win = RR ? (m_last_d ? 1 : 2) : 2;
      else if (IReq)    win = 1;
      else if (DReq)    win = 2;
      if (win == 1) begin
        m_owner = 1; m_base = IAddr & ~32'(BW * 4 - 1); m_we = 1'b0; m_beats = 0; m_last_d = 1'b0;
      end else if (win == 2) begin
        m_owner = 2; m_base = DAddr & ~32'(BW * 4 - 1); m_we = DWe; m_beats = 0; m_last_d = 1'b1;
      end
    end else if (MemAck) begin
      m_beats++;
      if (m_beats == BW) begin
        m_owner = 0;
        m_beats = 0;
      end
    end
  endtask

  // One clock: compare DUT against the model at the falling edge, advance at the rising edge.
  task automatic cycle();
    @(negedge CLK);
    model_eval();
    chk("MemReq",   MemReq,   e_req);
    chk("MemWe",    MemWe,    e_we);
    chk("MemAddr",  MemAddr,  e_addr);
    chk("MemWData", MemWData, e_wd);
    chk("Grant",    Grant,    e_grant);
    chk("Busy",     Busy,     e_busy);
    chk("IRValid",  IRValid,  e_irv);
    chk("IRData",   IRData,   e_ird);
    chk("IDone",    IDone,    e_idone);
    chk("DRValid",  DRValid,  e_drv);
    chk("DRData",   DRData,   e_drd);
    chk("DWReady",  DWReady,  e_dwr);
    chk("DDone",    DDone,    e_ddone);
    irv_pulses   += int'(IRValid);
    idone_pulses += int'(IDone);
    @(posedge CLK);
    model_step();
    #1;
  endtask

  // Requesters hold their request until their done pulse.
  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      cycle();
      if (e_idone) IReq = 1'b0;
      if (e_ddone) DReq = 1'b0;
    end
  endtask

  typedef struct {
    logic ireq; logic [31:0] iaddr; logic dreq; logic dwe; logic [31:0] daddr;
    logic ack;  logic [31:0] rdata;
    logic e_req; logic e_we; logic [31:0] e_addr; logic [1:0] e_grant;
    logic e_irv; logic [31:0] e_ird; logic e_idone; logic e_dwr; logic e_ddone;
  } vec_t;

  vec_t tbl [14];

  logic [1:0] first_g, second_g, exp_g;
  int         irv0, idone0;
  bit         i_pend, d_pend;

  initial begin
    // I refill at 0x1034 with MemAck every cycle, then D writeback at 0x2000 with acks 1,0,1,1,0,1.
    tbl[0]  = '{1'b1, 32'h1034, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    2'b00, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 32'h1034, 1'b0, 1'b0, 32'h0,    1'b1, 32'hA000_0001, 1'b1, 1'b0, 32'h1030, 2'b01, 1'b1, 32'hA000_0001, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 32'h1034, 1'b0, 1'b0, 32'h0,    1'b1, 32'hA000_0002, 1'b1, 1'b0, 32'h1034, 2'b01, 1'b1, 32'hA000_0002, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 32'h1034, 1'b0, 1'b0, 32'h0,    1'b1, 32'hA000_0003, 1'b1, 1'b0, 32'h1038, 2'b01, 1'b1, 32'hA000_0003, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 32'h1034, 1'b0, 1'b0, 32'h0,    1'b1, 32'hA000_0004, 1'b1, 1'b0, 32'h103C, 2'b01, 1'b1, 32'hA000_0004, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    2'b00, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h2000, 1'b0, 32'h5555_AAAA, 1'b0, 1'b0, 32'h0,    2'b00, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h2000, 1'b1, 32'h5555_AAAA, 1'b1, 1'b1, 32'h2000, 2'b10, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h2000, 1'b0, 32'h5555_AAAA, 1'b1, 1'b1, 32'h2004, 2'b10, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h2000, 1'b1, 32'h5555_AAAA, 1'b1, 1'b1, 32'h2004, 2'b10, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h2000, 1'b1, 32'h5555_AAAA, 1'b1, 1'b1, 32'h2008, 2'b10, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h2000, 1'b0, 32'h5555_AAAA, 1'b1, 1'b1, 32'h200C, 2'b10, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h2000, 1'b1, 32'h5555_AAAA, 1'b1, 1'b1, 32'h200C, 2'b10, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    2'b00, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0};

    ResetN = 1'b0; IReq = 1'b0; DReq = 1'b0; DWe = 1'b0; MemAck = 1'b0;
    IAddr = 32'h0; DAddr = 32'h0; DWData = 32'h0; MemRData = 32'h0;
    model_reset();
    #12;
    chk("reset_MemReq",  MemReq,  1'b0);
    chk("reset_Grant",   Grant,   2'b00);
    chk("reset_Busy",    Busy,    1'b0);
    chk("reset_MemAddr", MemAddr, 32'h0);
    @(posedge CLK); #1;
    ResetN = 1'b1;

    // ---- table-driven directed vectors ----
    for (int i = 0; i < 14; i++) begin
      IReq = tbl[i].ireq; IAddr = tbl[i].iaddr; DReq = tbl[i].dreq; DWe = tbl[i].dwe;
      DAddr = tbl[i].daddr; MemAck = tbl[i].ack; MemRData = tbl[i].rdata;
      DWData = 32'hC0DE_0000 + 32'(i);
      @(negedge CLK);
      chk($sformatf("tbl%0d_req",   i), MemReq,  tbl[i].e_req);
      chk($sformatf("tbl%0d_we",    i), MemWe,   tbl[i].e_we);
      chk($sformatf("tbl%0d_addr",  i), MemAddr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_grant", i), Grant,   tbl[i].e_grant);
      chk($sformatf("tbl%0d_busy",  i), Busy,    tbl[i].e_grant != 2'b00);
      chk($sformatf("tbl%0d_irv",   i), IRValid, tbl[i].e_irv);
      chk($sformatf("tbl%0d_ird",   i), IRData,  tbl[i].e_ird);
      chk($sformatf("tbl%0d_idone", i), IDone,   tbl[i].e_idone);
      chk($sformatf("tbl%0d_dwr",   i), DWReady, tbl[i].e_dwr);
      chk($sformatf("tbl%0d_ddone", i), DDone,   tbl[i].e_ddone);
      if (tbl[i].e_dwr) chk($sformatf("tbl%0d_wdata", i), MemWData, 32'hC0DE_0000 + 32'(i));
      @(posedge CLK);
      model_step();
      #1;
    end

    // ---- simultaneous requests: winner, one IDLE cycle, then loser ----
    // The last grant before this tie was D, so round-robin picks I.
    first_g  = RR ? 2'b01 : 2'b10;
    second_g = first_g ^ 2'b11;
    IReq = 1'b1; DReq = 1'b1; IAddr = 32'h4000; DAddr = 32'h5000; DWe = 1'b0;
    MemAck = 1'b1; MemRData = 32'h1111_2222;
    cycle();
    for (int k = 0; k < 10; k++) begin
      exp_g = (k < 4) ? first_g : ((k >= 5) && (k < 9)) ? second_g : 2'b00;
      chk($sformatf("tie1_grant%0d", k), Grant, exp_g);
      drain(1);
    end
    // Second tie: I then D were just granted, so round-robin picks I again; fixed priority picks D.
    IReq = 1'b1; DReq = 1'b1;
    cycle();
    chk("tie2_grant", Grant, RR ? 2'b01 : 2'b10);
    drain(10);
    chk("tie2_drained", Grant, 2'b00);

    // ---- I request arriving during a D writeback waits for DDone + one IDLE ----
    DReq = 1'b1; DAddr = 32'h6000; DWe = 1'b1; MemAck = 1'b1;
    cycle();
    IReq = 1'b1; IAddr = 32'h701C;
    irv0 = irv_pulses;
    drain(4);
    chk("wait_no_irv", irv_pulses - irv0, 0);
    chk("wait_idle_gap", Grant, 2'b00);
    IAddr = 32'h701C;
    cycle();
    chk("wait_grant_i", Grant, 2'b01);
    chk("wait_iaddr", MemAddr, 32'h7010);
    drain(5);

    // ---- requester drops IReq after the first beat; burst still completes ----
    IReq = 1'b1; IAddr = 32'h8004; MemAck = 1'b1;
    cycle();
    cycle();
    IReq = 1'b0; IAddr = 32'hFFFF_FFF0;
    irv0 = irv_pulses; idone0 = idone_pulses;
    drain(4);
    chk("drop_irv_pulses", irv_pulses - irv0, 3);
    chk("drop_idone", idone_pulses - idone0, 1);

    // ---- reset in the middle of a D refill ----
    DReq = 1'b1; DAddr = 32'h3000; DWe = 1'b0; MemAck = 1'b1; MemRData = 32'h7777_8888;
    cycle();
    cycle();
    cycle();
    ResetN = 1'b0;
    #1;
    chk("rst_MemReq",   MemReq,   1'b0);
    chk("rst_MemWe",    MemWe,    1'b0);
    chk("rst_MemAddr",  MemAddr,  32'h0);
    chk("rst_MemWData", MemWData, 32'h0);
    chk("rst_IRValid",  IRValid,  1'b0);
    chk("rst_DRValid",  DRValid,  1'b0);
    chk("rst_DRData",   DRData,   32'h0);
    chk("rst_DWReady",  DWReady,  1'b0);
    chk("rst_IDone",    IDone,    1'b0);
    chk("rst_DDone",    DDone,    1'b0);
    chk("rst_Grant",    Grant,    2'b00);
    chk("rst_Busy",     Busy,     1'b0);
    model_reset();
    @(posedge CLK); #1;
    ResetN = 1'b1; DReq = 1'b1; MemAck = 1'b0;
    cycle();
    chk("rst_restart_grant", Grant, 2'b10);
    chk("rst_restart_addr", MemAddr, 32'h3000);
    MemAck = 1'b1;
    drain(5);

    // ---- randomized traffic against the model ----
    i_pend = 1'b0; d_pend = 1'b0;
    for (int n = 0; n < 800; n++) begin
      if (!i_pend && ($urandom_range(0, 3) == 0)) i_pend = 1'b1;
      if (!d_pend && ($urandom_range(0, 3) == 0)) d_pend = 1'b1;
      IReq = i_pend; DReq = d_pend;
      IAddr = $urandom; DAddr = $urandom; DWe = 1'($urandom_range(0, 1));
      DWData = $urandom; MemRData = $urandom;
      MemAck = ($urandom_range(0, 9) < 7);
      cycle();
      if (e_idone) i_pend = 1'b0;
      if (e_ddone) d_pend = 1'b0;
    end
    MemAck = 1'b1;
    drain(12);
    chk("final_idle", Busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Arbitrates the single main-memory port between the I-cache and D-cache refill/writeback engines of the cached MIPS pipeline. It sits between the two cache controllers and main memory inside the cached top level. It grants one requester at a time and sequences a BLOCK_WORDS-beat burst with per-beat acknowledge. It routes read data and write-data pops to the granted cache and signals burst completion.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- BLOCK_WORDS, 4, beats per burst; must be a power of two, at least 2
- CLK  in  1  clock, rising edge
- ResetN  in  1  asynchronous, active-low reset
- IReq  in  1  I-cache burst request; held until IDone
- IAddr  in  ADDR_W  I-cache block address; low log2(BLOCK_WORDS)+2 bits ignored
- IRData  out  DATA_W  read beat to I-cache
- IRValid  out  1  IRData valid this cycle
- IDone  out  1  last beat of I burst completes this cycle
- DReq  in  1  D-cache burst request; held until DDone
- DWe  in  1  D burst is a writeback (1) or refill (0)
- DAddr  in  ADDR_W  D-cache block address; low bits ignored
- DWData  in  DATA_W  current write beat; advanced by D-cache after DWReady
- DWReady  out  1  current write beat accepted; D-cache presents next word
- DRData  out  DATA_W  read beat to D-cache
- DRValid  out  1  DRData valid this cycle
- DDone  out  1  last beat of D burst completes this cycle
- MemReq  out  1  beat request to memory
- MemWe  out  1  beat is a write
- MemAddr  out  ADDR_W  beat word address
- MemWData  out  DATA_W  write beat data
- MemRData  in  DATA_W  read beat data, valid with MemAck
- MemAck  in  1  memory accepts/returns current beat
- Grant  out  2  {D,I} one-hot owner, 00 when idle
- Busy  out  1  state not IDLE

## Operation
- States: IDLE, GRANT_I, GRANT_D.
- IDLE:
  - No request: stay in IDLE.
  - One request: go to its GRANT state.
  - Both requests: priority rule decides (see Configuration).
  - On the transition, latch the base address and write flag (DWe for D, 0 for I), and clear the beat counter.
- In a GRANT state:
  - MemReq=1, MemWe=latched flag.
  - MemAddr = {base[ADDR_W-1:log2(BLOCK_WORDS)+2], beat, 2'b00}.
  - MemWData = DWData, passed through combinationally.
- Per MemAck:
  - beat increments, with width log2(BLOCK_WORDS).
  - Read: xRData=MemRData and xRValid=1 in the same cycle (combinational).
  - Write: DWReady=1.
- MemAck on beat BLOCK_WORDS-1: xDone=1 that cycle; the next edge returns to IDLE and beat wraps to 0.
- No MemAck: hold state, address and beat; xRValid, DWReady and xDone stay 0.
- xRData outputs are 0 when that requester is not granted or MemAck=0.
- Request or input changes during a grant are ignored; the latched burst always completes.
- A requester that drops xReq early has no effect on the burst in progress.
- Requests from the non-granted side wait and are evaluated in the next IDLE cycle.
- Reset (async, any state): state=IDLE, beat=0, latches cleared.
  - All outputs are 0: MemReq, MemWe, MemAddr, MemWData, IRValid, DRValid, DWReady, IDone, DDone, Grant=00, Busy=0.
  - An abandoned memory beat is not resumed.

## Timing
- Request seen at edge k means the GRANT state holds from edge k and MemReq=1 in cycle k+1.
- Grant latency is 1 cycle; read data has zero latency from MemAck.
- Burst with MemAck every cycle: BLOCK_WORDS cycles of MemReq, then one mandatory IDLE cycle.
- Minimum occupancy is BLOCK_WORDS+1 cycles per burst.
- xDone is combinational. The requester deasserts xReq at the following edge, which is the same edge the arbiter enters IDLE. No spurious re-grant occurs.
- Back-to-back bursts from the same or the other requester are separated by exactly one IDLE cycle.

## Configuration
- ARB_RR_EN defined: round-robin tie-break.
  - A 1-bit last-granted register (reset value = D) is updated on each grant.
  - On simultaneous IReq and DReq, the side not last granted wins.
  - The first tie after reset goes to I.
- ARB_RR_EN undefined: fixed priority, D always wins ties. I may starve under continuous D traffic; this is accepted.

## Test plan
- I refill only, IAddr=0x0000_1034, MemAck every cycle -> MemAddr 0x1030,0x1034,0x1038,0x103C; IRValid 4 pulses carrying MemRData; IDone on 4th; Busy high 4 cycles, Grant=01.
- D writeback, DAddr=0x2000, DWe=1, MemAck pattern 1,0,1,1,0,1 -> MemWe=1; DWReady exactly 4 pulses aligned to acks; address held through gaps; DDone on 6th cycle.
- IReq and DReq raised same edge, macro undefined -> D burst first, one IDLE cycle, then I burst. Macro defined -> I first, then D. Second tie -> alternates.
- ResetN low after 2 acked beats of D refill -> all outputs 0 immediately. After release, new DReq restarts at beat 0 (MemAddr = base).
- IReq arrives during D grant -> no I response until DDone + 1 IDLE cycle, then GRANT_I with correct latched IAddr.
- Requester drops xReq mid-burst -> burst still completes all 4 beats and pulses xDone.
